// File: rtl/polynomial_evaluator.sv
// Signed fixed-point polynomial evaluator (Horner scheme) that drives one external
// fixed_point_mul over a start/done handshake and performs the accumulations itself.
//
// Handshakes:
//   start/done : start is sampled only while busy = 0 (i.e. in IDLE); a start seen while
//                busy is dropped, never queued. done is a one-cycle pulse with result
//                already valid in that cycle; result then holds until the next done.
//   mul_start/mul_done : mul_start is a one-cycle pulse with mul_a/mul_b valid. The
//                operands stay stable until mul_done is taken. The cycle right after
//                mul_start ignores mul_done, because the multiplier may still be reporting
//                an earlier product. mul_result is sampled in the cycle mul_done is taken.
module polynomial_evaluator #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int DEGREE                = 3,
  localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [NW-1:0]            x,
  input  logic [(DEGREE+1)*NW-1:0] coeffs,
  output logic [NW-1:0]            result,
  output logic                     mul_start,
  output logic [NW-1:0]            mul_a,
  output logic [NW-1:0]            mul_b,
  input  logic                     mul_done,
  input  logic [NW-1:0]            mul_result,
  output logic [2:0]               state_dbg
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_MUL_START    = 3'd1;
  localparam logic [2:0] S_MUL_SETTLE   = 3'd2;
  localparam logic [2:0] S_MUL_WAIT     = 3'd3;
  localparam logic [2:0] S_FINISH       = 3'd4;
  localparam logic [2:0] S_DRAIN_SETTLE = 3'd5;
  localparam logic [2:0] S_DRAIN_WAIT   = 3'd6;

  localparam int         KW    = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
  localparam logic [KW-1:0] K_TOP = KW'((DEGREE > 0) ? DEGREE - 1 : 0);

  logic [2:0]    state;
  logic [NW-1:0] acc;
  logic [NW-1:0] x_q;
  logic [NW-1:0] coef_q [DEGREE+1];
  logic [KW-1:0] k;
  logic [NW-1:0] acc_next;

  // The multiplier has no reset, so whether a product is still in flight must survive rst.
  logic mul_outstanding;
  logic mul_taken;
  logic outstanding_next;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign mul_start = (state == S_MUL_START);
  assign mul_a     = acc;
  assign mul_b     = x_q;
  assign state_dbg = state;

  // A product is consumed only where the FSM is actually listening for it.
  assign mul_taken = mul_done && ((state == S_MUL_WAIT) || (state == S_DRAIN_WAIT));

  // Flag value after this edge; also decides whether a reset must drain the multiplier.
  always_comb begin
    outstanding_next = mul_outstanding;
    if (state == S_MUL_START) begin
      outstanding_next = 1'b1;
    end else if (mul_taken) begin
      outstanding_next = 1'b0;
    end
  end

  // Horner step: wraps in NW bits, no saturation.
  assign acc_next = mul_result + coef_q[k];

  // In-flight product tracking, deliberately outside the rst domain.
  always_ff @(posedge clk) begin
    mul_outstanding <= outstanding_next;
  end

  // Main sequencer: latch operands, issue products, accumulate, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= outstanding_next ? S_DRAIN_SETTLE : S_IDLE;
      acc    <= '0;
      x_q    <= '0;
      k      <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q <= x;
            for (int i = 0; i <= DEGREE; i++) begin
              coef_q[i] <= coeffs[i*NW +: NW];
            end
            acc <= coeffs[DEGREE*NW +: NW];
            k   <= K_TOP;
            if (DEGREE > 0) begin
              state <= S_MUL_START;
            end else begin
              // Constant polynomial: result is c0, ready for the done cycle.
              result <= coeffs[DEGREE*NW +: NW];
              state  <= S_FINISH;
            end
          end
        end
        S_MUL_START: begin
          state <= S_MUL_SETTLE;
        end
        S_MUL_SETTLE: begin
          state <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (mul_done) begin
            acc <= acc_next;
            if (k == '0) begin
              // Load result now so it is already valid while done is high.
              result <= acc_next;
              state  <= S_FINISH;
            end else begin
              k     <= k - 1'b1;
              state <= S_MUL_START;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        S_DRAIN_SETTLE: begin
          state <= S_DRAIN_WAIT;
        end
        S_DRAIN_WAIT: begin
          // Stale product is discarded; only the flag (cleared above) cares.
          if (mul_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polynomial_evaluator.sv
// Bench for polynomial_evaluator: a behavioural fixed_point_mul with programmable extra
// latency, a directed vector table, hand-written multi-cycle sequences and random runs
// checked against a plain-arithmetic reference evaluation.
`timescale 1ns/1ps
module tb_polynomial_evaluator;

  localparam int IW = 8;
  localparam int FW = 8;
  localparam int D  = 3;
  localparam int NW = IW + FW;
  localparam int CW = (D + 1) * NW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- main DUT (DEGREE = 3) ----------------
  logic          start = 1'b0;
  logic [NW-1:0] x = '0;
  logic [CW-1:0] coeffs = '0;
  logic          busy, done, mul_start;
  logic [NW-1:0] result, mul_a, mul_b;
  logic          mul_done = 1'b0;
  logic [NW-1:0] mul_result = '0;
  logic [2:0]    state_dbg;

  polynomial_evaluator #(.INTEGER_PART_WIDTH(IW), .FRACTIONAL_PART_WIDTH(FW), .DEGREE(D)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .x(x), .coeffs(coeffs),
    .result(result), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .state_dbg(state_dbg)
  );

  // ---------------- second DUT (DEGREE = 0) ----------------
  logic          start0 = 1'b0;
  logic [NW-1:0] x0 = '0;
  logic [NW-1:0] coeffs0 = '0;
  logic          busy0, done0, mul_start0;
  logic [NW-1:0] result0, mul_a0, mul_b0;
  logic          mul_done0 = 1'b0;
  logic [NW-1:0] mul_result0 = '0;
  logic [2:0]    state_dbg0;

  polynomial_evaluator #(.INTEGER_PART_WIDTH(IW), .FRACTIONAL_PART_WIDTH(FW), .DEGREE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .x(x0), .coeffs(coeffs0),
    .result(result0), .mul_start(mul_start0), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_done(mul_done0), .mul_result(mul_result0), .state_dbg(state_dbg0)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [NW-1:0] fxmul(input logic [NW-1:0] a, input logic [NW-1:0] b);
    logic signed [2*NW-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FW+NW-1:FW];
  endfunction

  function automatic logic [NW-1:0] ref_poly(input logic [NW-1:0] xv, input logic [CW-1:0] cv);
    logic [NW-1:0] p;
    p = cv[D*NW +: NW];
    for (int j = D - 1; j >= 0; j--) p = fxmul(p, xv) + cv[j*NW +: NW];
    return p;
  endfunction

  // ---------------- fixed_point_mul model (no reset) ----------------
  int            mul_lat = 0;
  logic [NW-1:0] mp_val = '0;
  int            mp_cnt = 0;
  bit            mp_pend = 1'b0;
  always @(posedge clk) begin
    if (mul_start) begin
      mp_val   <= fxmul(mul_a, mul_b);
      mp_cnt   <= mul_lat;
      mp_pend  <= 1'b1;
      mul_done <= 1'b0;
    end else if (mp_pend && mp_cnt == 0) begin
      mul_done   <= 1'b1;
      mul_result <= mp_val;
      mp_pend    <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mp_pend) mp_cnt <= mp_cnt - 1;
    end
  end

  int mul0_cnt = 0;
  always @(negedge clk) begin
    if (mul_start0) mul0_cnt <= mul0_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [NW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_eval(input logic [NW-1:0] xv, input logic [CW-1:0] cv, input int lat,
                          output logic [NW-1:0] res, output int cyc, output logic busy_seen);
    @(negedge clk);
    mul_lat = lat;
    x = xv;
    coeffs = cv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = NW'($urandom);
    coeffs = {$urandom, $urandom};
    cyc = 1;
    busy_seen = busy;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    res = result;
    if (!done) cyc = -1;
  endtask

  typedef struct {
    logic [NW-1:0] xv;
    logic [CW-1:0] cv;
    int            lat;
    logic [NW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NW-1:0] res;
    int cyc;
    logic bs;
    int dones;
    logic [NW-1:0] res_at_done;
    bit saw_mdone;
    int bad_out;

    // coeffs packed as {c3, c2, c1, c0}
    vecs[0] = '{16'h0200, {16'h0100, 16'h0000, 16'h0000, 16'h0000}, 0, 16'h0800};
    vecs[1] = '{16'hFE80, {16'h0000, 16'h0000, 16'h0300, 16'h0200}, 0, 16'hFD80};
    vecs[2] = '{16'h0100, {16'h0000, 16'h0000, 16'h0100, 16'h7F00}, 2, 16'h8000};
    vecs[3] = '{16'h0000, {16'h0500, 16'hF300, 16'h0700, 16'h1234}, 1, 16'h1234};
    vecs[4] = '{16'h0080, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 3, 16'h01E0};
    vecs[5] = '{16'hFF00, {16'h0100, 16'h0000, 16'h0000, 16'h0000}, 0, 16'hFF00};

    // ---- reset, with start held high (rst wins) ----
    rst = 1'b1;
    start = 1'b1;
    start0 = 1'b1;
    x = 16'h0200;
    coeffs = {16'h0100, 48'h0};
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_result", result, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_busy0", busy0, 0);
    check("rst_result0", result0, 0);
    rst = 1'b0;
    start = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    // ---- directed table ----
    for (int i = 0; i < 6; i++) begin
      run_eval(vecs[i].xv, vecs[i].cv, vecs[i].lat, res, cyc, bs);
      check($sformatf("vec%0d_busy", i), bs, 1);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), cyc, 3 * D + 1 + D * vecs[i].lat);
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), {busy, done}, 2'b00);
      check($sformatf("vec%0d_held", i), result, vecs[i].exp);
    end

    // ---- start re-pulsed at cycles 2 and 5 of a run ----
    @(negedge clk);
    mul_lat = 0;
    x = 16'h0200;
    coeffs = {16'h0100, 48'h0};
    start = 1'b1;
    dones = 0;
    res_at_done = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        res_at_done = result;
      end
      start = (c == 2 || c == 5);
      x = NW'($urandom);
      coeffs = {$urandom, $urandom};
    end
    start = 1'b0;
    check("repulse_done_count", dones, 1);
    check("repulse_result", res_at_done, 16'h0800);

    // ---- reset during MUL_WAIT, drain, then a clean run ----
    @(negedge clk);
    mul_lat = 6;
    x = 16'h0200;
    coeffs = {16'h0100, 48'h0};
    start = 1'b1;
    @(negedge clk);              // MUL_START
    start = 1'b0;
    @(negedge clk);              // settle
    @(negedge clk);              // first wait cycle
    rst = 1'b1;
    @(negedge clk);              // first cycle after the reset edge
    rst = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_done", done, 0);
    check("drain_result", result, 0);
    check("drain_mul_start", mul_start, 0);
    dones = 0;
    bad_out = 0;
    saw_mdone = 1'b0;
    for (int c = 0; c < 50; c++) begin
      start = (c < 3);
      x = 16'hFE80;
      coeffs = {16'h0000, 16'h0000, 16'h0300, 16'h0200};
      if (!busy) break;
      if (done) dones++;
      if (mul_start || result != '0) bad_out++;
      if (mul_done) saw_mdone = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check("drain_ended", busy, 0);
    check("drain_waited_mul", saw_mdone, 1);
    check("drain_no_done", dones, 0);
    check("drain_clean_outputs", bad_out, 0);
    check("drain_stale_result", result, 0);
    @(negedge clk);
    check("drain_start_not_queued", busy, 0);
    run_eval(16'hFE80, {16'h0000, 16'h0000, 16'h0300, 16'h0200}, 0, res, cyc, bs);
    check("after_drain_result", res, 16'hFD80);
    check("after_drain_latency", cyc, 3 * D + 1);

    // ---- DEGREE = 0 instance ----
    @(negedge clk);
    x0 = NW'($urandom);
    coeffs0 = 16'h1234;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    coeffs0 = 16'h0000;
    check("deg0_done", done0, 1);
    check("deg0_result", result0, 16'h1234);
    @(negedge clk);
    check("deg0_idle", {busy0, done0}, 2'b00);
    check("deg0_held", result0, 16'h1234);

    // ---- random runs against the reference model ----
    for (int i = 0; i < 40; i++) begin
      logic [NW-1:0] xv;
      logic [CW-1:0] cv;
      int lat;
      xv = NW'($urandom_range(0, 65535));
      cv = {$urandom, $urandom};
      lat = $urandom_range(0, 3);
      exp_q.push_back(ref_poly(xv, cv));
      run_eval(xv, cv, lat, res, cyc, bs);
      check($sformatf("rand%0d_result", i), res, exp_q.pop_front());
      check($sformatf("rand%0d_latency", i), cyc, 3 * D + 1 + D * lat);
    end

    @(posedge clk);
    #1;
    check("deg0_no_mul_start", mul0_cnt, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
